// File: rtl/atm_terminal_ctrl_if.sv
// Request/response channel between the ATM terminal controller (master) and the account core (slave).
interface atm_terminal_ctrl_if #(
    parameter int AMT_W = 10
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_select;
    logic [3:0]       req_origin;
    logic [3:0]       req_purpose;
    logic [AMT_W-1:0] req_amount;
    logic             resp_valid;
    logic [1:0]       resp_result;
    logic [AMT_W-1:0] resp_balance;

    modport master (
        output req_valid, req_select, req_origin, req_purpose, req_amount,
        input  req_ready, resp_valid, resp_result, resp_balance
    );

    modport slave (
        input  req_valid, req_select, req_origin, req_purpose, req_amount,
        output req_ready, resp_valid, resp_result, resp_balance
    );
endinterface

// File: rtl/atm_terminal_ctrl.sv
// ATM terminal controller: gathers keypad fields, issues one request to the account core,
// waits for the response with a timeout and holds the outcome for the display.
module atm_terminal_ctrl #(
    parameter int AMT_W       = 10,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SHOW_CYC    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid_i,
    input  logic [3:0]       key_code_i,
    atm_terminal_ctrl_if.master core_if,
    output logic             disp_valid_o,
    output logic [1:0]       disp_result_o,
    output logic [AMT_W-1:0] disp_balance_o,
    output logic             timeout_o,
    output logic             entry_err_o,
    output logic             busy_o
);
    localparam int CNT_MAX = (TIMEOUT_CYC > SHOW_CYC) ? TIMEOUT_CYC : SHOW_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AW4     = AMT_W + 4;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ORIG, S_GET_SEL, S_GET_AMT, S_GET_DEST, S_SEND, S_WAIT_RESP, S_SHOW
    } state_e;

    typedef struct packed {
        logic [3:0]       origin;
        logic             orig_set;
        logic [1:0]       select;
        logic [AMT_W-1:0] amount;
        logic [3:0]       purpose;
        logic             dest_set;
    } fields_t;

    state_e           state_q, state_d;
    fields_t          fields_q, fields_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       disp_result_q, disp_result_d;
    logic [AMT_W-1:0] disp_balance_q, disp_balance_d;
    logic             timeout_q, timeout_d;
    logic             entry_err_q, entry_err_d;

    logic             key_digit, key_enter, key_cancel, key_wake, in_entry;
    logic [AW4-1:0]   amt_calc;
    logic             amt_ovf;

    assign key_digit  = key_valid_i && (key_code_i <= 4'd9);
    assign key_enter  = key_valid_i && (key_code_i == 4'd10);
    assign key_cancel = key_valid_i && (key_code_i == 4'd11);
    assign key_wake   = key_valid_i && (key_code_i <= 4'd11);
    assign in_entry   = (state_q == S_GET_ORIG) || (state_q == S_GET_SEL) ||
                        (state_q == S_GET_AMT)  || (state_q == S_GET_DEST);

    // Decimal shift-in is evaluated four bits wider so an overflowing digit can be rejected.
    assign amt_calc = AW4'(fields_q.amount) * AW4'(10) + AW4'(key_code_i);
    assign amt_ovf  = |amt_calc[AW4-1:AMT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            fields_q       <= '0;
            timer_q        <= '0;
            disp_result_q  <= '0;
            disp_balance_q <= '0;
            timeout_q      <= 1'b0;
            entry_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            fields_q       <= fields_d;
            timer_q        <= timer_d;
            disp_result_q  <= disp_result_d;
            disp_balance_q <= disp_balance_d;
            timeout_q      <= timeout_d;
            entry_err_q    <= entry_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fields_d       = fields_q;
        timer_d        = timer_q;
        disp_result_d  = disp_result_q;
        disp_balance_d = disp_balance_q;
        timeout_d      = timeout_q;
        entry_err_d    = 1'b0;

        if (in_entry && key_cancel) begin
            fields_d = '0;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_wake) state_d = S_GET_ORIG;
                end
                S_GET_ORIG: begin
                    if (key_digit) begin
                        fields_d.origin   = key_code_i;
                        fields_d.orig_set = 1'b1;
                    end else if (key_enter) begin
                        if (fields_q.orig_set) state_d = S_GET_SEL;
                        else                   entry_err_d = 1'b1;
                    end
                end
                S_GET_SEL: begin
                    if (key_digit) begin
                        if (key_code_i >= 4'd1 && key_code_i <= 4'd3) fields_d.select = key_code_i[1:0];
                        else                                          entry_err_d = 1'b1;
                    end else if (key_enter) begin
                        state_d = (fields_q.select == 2'd1) ? S_SEND : S_GET_AMT;
                    end
                end
                S_GET_AMT: begin
                    if (key_digit) begin
                        if (amt_ovf) entry_err_d     = 1'b1;
                        else         fields_d.amount = amt_calc[AMT_W-1:0];
                    end else if (key_enter) begin
                        if (fields_q.amount == '0) entry_err_d = 1'b1;
                        else state_d = (fields_q.select == 2'd3) ? S_GET_DEST : S_SEND;
                    end
                end
                S_GET_DEST: begin
                    if (key_digit) begin
                        fields_d.purpose  = key_code_i;
                        fields_d.dest_set = 1'b1;
                    end else if (key_enter) begin
                        if (!fields_q.dest_set || fields_q.purpose == fields_q.origin) entry_err_d = 1'b1;
                        else state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (core_if.req_ready) begin
                        state_d = S_WAIT_RESP;
                        timer_d = '0;
                    end
                end
                S_WAIT_RESP: begin
                    // A response arriving on the expiry cycle still takes priority over the timeout.
                    if (core_if.resp_valid) begin
                        disp_result_d  = core_if.resp_result;
                        disp_balance_d = core_if.resp_balance;
                        timeout_d      = 1'b0;
                        timer_d        = '0;
                        state_d        = S_SHOW;
                    end else if (timer_q == TO_LAST) begin
                        disp_result_d  = '0;
                        disp_balance_d = '0;
                        timeout_d      = 1'b1;
                        timer_d        = '0;
                        state_d        = S_SHOW;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        fields_d       = '0;
                        disp_result_d  = '0;
                        disp_balance_d = '0;
                        timeout_d      = 1'b0;
                        timer_d        = '0;
                        state_d        = S_IDLE;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign core_if.req_valid   = (state_q == S_SEND);
    assign core_if.req_select  = fields_q.select;
    assign core_if.req_origin  = fields_q.origin;
    assign core_if.req_purpose = fields_q.purpose;
    assign core_if.req_amount  = fields_q.amount;

    assign disp_valid_o   = (state_q == S_SHOW);
    assign disp_result_o  = disp_result_q;
    assign disp_balance_o = disp_balance_q;
    assign timeout_o      = timeout_q;
    assign entry_err_o    = entry_err_q;
    assign busy_o         = (state_q != S_IDLE);
endmodule

// File: tb/tb_atm_terminal_ctrl.sv
// Bench for atm_terminal_ctrl: directed scenarios plus random keypad/core traffic, checked every
// cycle against a rule-level model of the terminal.
module tb_atm_terminal_ctrl;
    localparam int AMT_W       = 10;
    localparam int TIMEOUT_CYC = 1000;
    localparam int SHOW_CYC    = 16;
    localparam int AMT_MAX     = (1 << AMT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_valid = 1'b0;
    logic [3:0]       key_code = 4'd0;
    logic             disp_valid;
    logic [1:0]       disp_result;
    logic [AMT_W-1:0] disp_balance;
    logic             timeout;
    logic             entry_err;
    logic             busy;

    atm_terminal_ctrl_if #(.AMT_W(AMT_W)) bus ();

    atm_terminal_ctrl #(.AMT_W(AMT_W), .TIMEOUT_CYC(TIMEOUT_CYC), .SHOW_CYC(SHOW_CYC)) dut (
        .clk(clk), .rst(rst), .key_valid_i(key_valid), .key_code_i(key_code), .core_if(bus.master),
        .disp_valid_o(disp_valid), .disp_result_o(disp_result), .disp_balance_o(disp_balance),
        .timeout_o(timeout), .entry_err_o(entry_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, n_print = 0;
    bit chk_en = 0;
    int tb_cyc = 0;
    always @(posedge clk) tb_cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s cyc=%0d: actual %0d required %0d", nm, tb_cyc, act, exp);
            end
        end
    endtask

    // ---------------- core responder configuration ----------------
    int         cfg_ready_delay = 0;
    int         cfg_resp_delay  = 0;   // -1: never respond
    bit         cfg_rand_resp   = 0;
    bit         cfg_spurious    = 0;
    logic [1:0] cfg_result      = 2'd3;
    logic [AMT_W-1:0] cfg_balance = '0;

    initial begin
        bit hs, rst_s, waiting;
        int rdy_cnt, resp_cnt;
        waiting = 0; rdy_cnt = 0; resp_cnt = 0;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_result = '0; bus.resp_balance = '0;
        forever begin
            @(posedge clk);
            hs    = bus.req_valid && bus.req_ready;
            rst_s = rst;
            #1;
            bus.req_ready  = 1'b0;
            bus.resp_valid = 1'b0;
            if (rst_s) waiting = 0;
            else if (hs) begin
                waiting  = (cfg_resp_delay >= 0);
                resp_cnt = 0;
            end
            if (waiting) begin
                if (resp_cnt >= cfg_resp_delay) begin
                    bus.resp_valid   = 1'b1;
                    bus.resp_result  = cfg_rand_resp ? 2'($urandom_range(0, 3)) : cfg_result;
                    bus.resp_balance = cfg_rand_resp ? AMT_W'($urandom_range(0, AMT_MAX)) : cfg_balance;
                    waiting = 0;
                end else resp_cnt++;
            end
            if (bus.req_valid) begin
                if (rdy_cnt >= cfg_ready_delay) begin
                    bus.req_ready = 1'b1;
                    if (cfg_spurious) begin
                        bus.resp_valid   = 1'b1;
                        bus.resp_result  = 2'($urandom_range(0, 3));
                        bus.resp_balance = AMT_W'($urandom_range(0, AMT_MAX));
                    end
                end else rdy_cnt++;
            end else rdy_cnt = 0;
        end
    end

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_ORIG = 1, P_SEL = 2, P_AMT = 3, P_DEST = 4, P_SEND = 5, P_WAIT = 6, P_SHOW = 7;
    int m_ph = P_IDLE, m_orig = 0, m_sel = 0, m_amt = 0, m_dest = 0, m_dres = 0, m_dbal = 0;
    bit m_has_orig = 0, m_has_dest = 0, m_to = 0, m_err = 0;
    int m_cyc = 0, m_wait_at = 0, m_show_at = 0;

    function automatic void m_clear();
        m_orig = 0; m_sel = 0; m_amt = 0; m_dest = 0; m_has_orig = 0; m_has_dest = 0;
    endfunction

    always @(posedge clk) begin
        int kc;
        m_cyc++;
        m_err = 0;
        kc = int'(key_code);
        if (rst) begin
            m_ph = P_IDLE; m_clear(); m_dres = 0; m_dbal = 0; m_to = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (key_valid && kc <= 11) m_ph = P_ORIG;
                P_ORIG, P_SEL, P_AMT, P_DEST: begin
                    if (key_valid && kc == 11) begin
                        m_clear(); m_ph = P_IDLE;
                    end else if (key_valid && kc <= 10) begin
                        case (m_ph)
                            P_ORIG: if (kc == 10) begin
                                        if (m_has_orig) m_ph = P_SEL; else m_err = 1;
                                    end else begin m_orig = kc; m_has_orig = 1; end
                            P_SEL:  if (kc == 10) m_ph = (m_sel == 1) ? P_SEND : P_AMT;
                                    else if (kc >= 1 && kc <= 3) m_sel = kc;
                                    else m_err = 1;
                            P_AMT:  if (kc == 10) begin
                                        if (m_amt == 0) m_err = 1;
                                        else m_ph = (m_sel == 3) ? P_DEST : P_SEND;
                                    end else if (m_amt * 10 + kc > AMT_MAX) m_err = 1;
                                    else m_amt = m_amt * 10 + kc;
                            default: if (kc == 10) begin
                                        if (!m_has_dest || m_dest == m_orig) m_err = 1; else m_ph = P_SEND;
                                    end else begin m_dest = kc; m_has_dest = 1; end
                        endcase
                    end
                end
                P_SEND: if (bus.req_ready) begin m_ph = P_WAIT; m_wait_at = m_cyc; end
                P_WAIT: begin
                    if (bus.resp_valid) begin
                        m_dres = bus.resp_result; m_dbal = bus.resp_balance; m_to = 0;
                        m_ph = P_SHOW; m_show_at = m_cyc;
                    end else if (m_cyc - m_wait_at == TIMEOUT_CYC) begin
                        m_dres = 0; m_dbal = 0; m_to = 1; m_ph = P_SHOW; m_show_at = m_cyc;
                    end
                end
                default: if (m_cyc - m_show_at == SHOW_CYC) begin
                    m_clear(); m_dres = 0; m_dbal = 0; m_to = 0; m_ph = P_IDLE;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_ph != P_IDLE);
            chk("req_valid", bus.req_valid, m_ph == P_SEND);
            if (m_ph == P_SEND || m_ph == P_IDLE) begin
                chk("req_select", bus.req_select, m_sel);
                chk("req_origin", bus.req_origin, m_orig);
                chk("req_purpose", bus.req_purpose, m_dest);
                chk("req_amount", bus.req_amount, m_amt);
            end
            chk("disp_valid", disp_valid, m_ph == P_SHOW);
            chk("disp_result", disp_result, m_dres);
            chk("disp_balance", disp_balance, m_dbal);
            chk("timeout", timeout, m_to);
            chk("entry_err", entry_err, m_err);
        end
    end

    // ---------------- transaction monitor ----------------
    int hs_cnt = 0, hs_cyc = 0, valid_run = 0, total_valid = 0, last_valid_len = 0;
    int last_sel = 0, last_orig = 0, last_purp = 0, last_amt = 0;
    int show_cyc = 0, show_run = 0, last_show_len = 0, last_dres = 0, last_dbal = 0, last_to = 0;
    int err_cnt = 0;
    bit prev_disp = 0;

    always @(negedge clk) begin
        if (rst) valid_run = 0;
        if (bus.req_valid) begin valid_run++; total_valid++; end
        if (bus.req_valid && bus.req_ready) begin
            hs_cnt++; hs_cyc = tb_cyc; last_valid_len = valid_run; valid_run = 0;
            last_sel = bus.req_select; last_orig = bus.req_origin;
            last_purp = bus.req_purpose; last_amt = bus.req_amount;
        end
        if (disp_valid && !prev_disp) begin
            show_cyc = tb_cyc; last_dres = disp_result; last_dbal = disp_balance; last_to = timeout;
        end
        if (disp_valid) show_run++;
        else if (prev_disp) begin last_show_len = show_run; show_run = 0; end
        if (entry_err) err_cnt++;
        prev_disp = disp_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [3:0] k, input int gap);
        @(posedge clk); #1;
        key_valid = 1'b1; key_code = k;
        @(posedge clk); #1;
        key_valid = 1'b0; key_code = 4'($urandom_range(0, 15));
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
        chk("idle_reached", busy, 1'b0);
        @(negedge clk); #1;
    endtask

    function automatic logic [3:0] rand_key();
        int r = $urandom_range(0, 99);
        if (r < 55)      return 4'($urandom_range(0, 9));
        else if (r < 85) return 4'd10;
        else if (r < 90) return 4'd11;
        else             return 4'($urandom_range(12, 15));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0, e0, v0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", bus.req_valid, 1'b0);
        chk("rst_disp_valid", disp_valid, 1'b0);
        rst = 1'b0;
        chk_en = 1;

        // 1: balance enquiry
        cfg_ready_delay = 0; cfg_resp_delay = 0; cfg_rand_resp = 0; cfg_spurious = 0;
        cfg_result = 2'd3; cfg_balance = AMT_W'(100);
        hs0 = hs_cnt;
        press(4'd10, 0); press(4'd7, 0); press(4'd10, 0); press(4'd1, 0); press(4'd10, 0);
        wait_idle(3000);
        chk("t1_hs", hs_cnt - hs0, 1);
        chk("t1_select", last_sel, 1);
        chk("t1_origin", last_orig, 7);
        chk("t1_purpose", last_purp, 0);
        chk("t1_amount", last_amt, 0);
        chk("t1_disp_result", last_dres, 3);
        chk("t1_disp_balance", last_dbal, 100);
        chk("t1_show_len", last_show_len, 16);

        // 2: transfer with 5 cycles of backpressure
        cfg_ready_delay = 5; cfg_resp_delay = 2; cfg_result = 2'd3; cfg_balance = AMT_W'(7);
        hs0 = hs_cnt;
        press(4'd10, 0); press(4'd2, 0); press(4'd10, 0); press(4'd3, 0); press(4'd10, 0);
        press(4'd5, 0); press(4'd0, 0); press(4'd10, 0); press(4'd9, 0); press(4'd10, 0);
        wait_idle(3000);
        chk("t2_hs", hs_cnt - hs0, 1);
        chk("t2_select", last_sel, 3);
        chk("t2_origin", last_orig, 2);
        chk("t2_purpose", last_purp, 9);
        chk("t2_amount", last_amt, 50);
        chk("t2_valid_len", last_valid_len, 6);

        // 3: amount overflow on the fourth digit
        cfg_ready_delay = 0; cfg_resp_delay = 1; cfg_result = 2'd1; cfg_balance = AMT_W'(0);
        e0 = err_cnt;
        press(4'd10, 0); press(4'd4, 0); press(4'd10, 0); press(4'd2, 0); press(4'd10, 0);
        press(4'd1, 0); press(4'd0, 0); press(4'd2, 0); press(4'd4, 0); press(4'd10, 0);
        wait_idle(3000);
        chk("t3_err_count", err_cnt - e0, 1);
        chk("t3_amount", last_amt, 102);
        chk("t3_select", last_sel, 2);
        chk("t3_disp_result", last_dres, 1);

        // 4: timeout, then a late response landing in the display hold
        cfg_resp_delay = 1005; cfg_result = 2'd3; cfg_balance = AMT_W'(55);
        press(4'd10, 0); press(4'd3, 0); press(4'd10, 0); press(4'd2, 0); press(4'd10, 0);
        press(4'd5, 0); press(4'd10, 0);
        wait_idle(3000);
        chk("t4_timeout", last_to, 1);
        chk("t4_disp_result", last_dres, 0);
        chk("t4_disp_balance", last_dbal, 0);
        chk("t4_wait_len", show_cyc - hs_cyc, 1001);
        chk("t4_show_len", last_show_len, 16);

        // 5: rejected keys and cancel
        cfg_resp_delay = 0;
        e0 = err_cnt; v0 = total_valid;
        press(4'd10, 0); press(4'd3, 0); press(4'd10, 0); press(4'd0, 0); press(4'd3, 0);
        press(4'd10, 0); press(4'd7, 0); press(4'd10, 0); press(4'd3, 0); press(4'd10, 0);
        press(4'd11, 0);
        @(negedge clk); #1;
        chk("t5_err_count", err_cnt - e0, 2);
        chk("t5_no_request", total_valid - v0, 0);
        chk("t5_idle", busy, 1'b0);

        // 6: reset while waiting for the response
        cfg_resp_delay = -1;
        press(4'd10, 0); press(4'd1, 0); press(4'd10, 0); press(4'd2, 0); press(4'd10, 0);
        press(4'd9, 0); press(4'd10, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_req_valid", bus.req_valid, 1'b0);
        chk("t6_req_amount", bus.req_amount, 0);
        chk("t6_req_origin", bus.req_origin, 0);
        chk("t6_disp_valid", disp_valid, 1'b0);
        chk("t6_timeout", timeout, 1'b0);
        chk("t6_entry_err", entry_err, 1'b0);
        rst = 1'b0;
        cfg_resp_delay = 0; cfg_result = 2'd3; cfg_balance = AMT_W'(321);
        hs0 = hs_cnt;
        press(4'd10, 0); press(4'd6, 0); press(4'd10, 0); press(4'd1, 0); press(4'd10, 0);
        wait_idle(3000);
        chk("t6_hs", hs_cnt - hs0, 1);
        chk("t6_origin", last_orig, 6);
        chk("t6_disp_balance", last_dbal, 321);

        // random traffic against the model
        cfg_rand_resp = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) begin
                int r;
                r = $urandom_range(0, 29);
                cfg_ready_delay = $urandom_range(0, 4);
                cfg_spurious    = ($urandom_range(0, 3) == 0);
                if (r == 0)      cfg_resp_delay = TIMEOUT_CYC - 2 + $urandom_range(0, 2);
                else if (r == 1) cfg_resp_delay = -1;
                else             cfg_resp_delay = $urandom_range(0, 6);
            end
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk); #1; rst = 1'b1;
                @(posedge clk); #1; rst = 1'b0;
            end
            press(rand_key(), $urandom_range(0, 2));
        end
        press(4'd11, 0);
        wait_idle(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
